decode_ex_pipe: RTL and testbench

//  Decode-to-execute pipeline stage. Captures a decoded instruction bundle and forms the
//  7-bit ALU op-extension {instr[15:11], instr[1:0]} consumed by the ALU control decoder.

---
 rtl/decode_ex_pipe_pkg.sv | 27 ++
 rtl/decode_ex_pipe_if.sv | 46 ++++
 rtl/dx_pipe_slot.sv | 41 ++++
 rtl/decode_ex_pipe.sv | 143 ++++++++++++++
 tb/tb_decode_ex_pipe.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_ex_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_ex_pipe_pkg                                           |
// | Description : Shared constants for the decode-to-execute pipeline stage:   |
// |               ALU op-extension field positions and control state codes.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package decode_ex_pipe_pkg;

    // ALU op-extension: {opcode[4:0], func[1:0]}
    localparam int OPEXT_W = 7;
    // Opcode occupies the top OPC_W bits of the instruction
    localparam int OPC_W   = 5;
    // Function field position (low bits of the instruction)
    localparam int FUNC_HI = 1;
    localparam int FUNC_LO = 0;

    // Bundle = instr + pc_inc + rs + rt + imm
    localparam int BUNDLE_DATA_FIELDS = 4;

    // Control state: bit0 = main slot occupied, bit1 = skid slot occupied
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/decode_ex_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_ex_pipe_if                                            |
// | Description : Valid/ready bus between decode, the decode-to-execute stage  |
// |               and execute. The stage is the slave side.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface decode_ex_pipe_if
    import decode_ex_pipe_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_W-1:0]   in_instr;
    logic [DATA_W-1:0]    in_pc_inc;
    logic [DATA_W-1:0]    in_rs_data;
    logic [DATA_W-1:0]    in_rt_data;
    logic [DATA_W-1:0]    in_imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSTR_W-1:0]   out_instr;
    logic [OPEXT_W-1:0]   out_op_ext;
    logic [DATA_W-1:0]    out_pc_inc;
    logic [DATA_W-1:0]    out_rs_data;
    logic [DATA_W-1:0]    out_rt_data;
    logic [DATA_W-1:0]    out_imm;

    modport master (
        output flush, in_valid, in_instr, in_pc_inc, in_rs_data, in_rt_data, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_op_ext, out_pc_inc,
        input  out_rs_data, out_rt_data, out_imm
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc_inc, in_rs_data, in_rt_data, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_op_ext, out_pc_inc,
        output out_rs_data, out_rt_data, out_imm
    );

endinterface
`default_nettype wire

// File: rtl/dx_pipe_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dx_pipe_slot                                                 |
// | Description : One bundle holding register with valid bit. Loads on         |
// |               i_load, invalidates on i_clr (clear wins), data held          |
// |               otherwise.                                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dx_pipe_slot #(
    parameter int WIDTH = 80
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic             i_clr,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q,
    output logic                  o_valid
);

    logic [WIDTH-1:0] r_q;
    logic             r_valid;

    // Slot storage: data only changes on a load; a clear drops the valid bit only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_q     <= i_d;
            r_valid <= 1'b1;
        end
    end

    assign o_q     = r_q;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/decode_ex_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_ex_pipe                                               |
// | Description : Decode-to-execute stage with a 2-entry skid buffer. in_ready |
// |               comes straight from the skid valid flop so execute stalls    |
// |               never reach decode combinationally. Forms the ALU op-ext.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decode_ex_pipe
    import decode_ex_pipe_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    decode_ex_pipe_if.slave bus
);

    localparam int c_BUNDLE_W = INSTR_W + BUNDLE_DATA_FIELDS * DATA_W;
    localparam int c_OPC_HI   = INSTR_W - 1;
    localparam int c_OPC_LO   = INSTR_W - OPC_W;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_main_load;
    logic                  w_main_clr;
    logic                  w_main_from_skid;
    logic                  w_skid_load;
    logic                  w_skid_clr;
    logic                  w_main_v;
    logic                  w_skid_v;
    logic [c_BUNDLE_W-1:0] w_in_bundle;
    logic [c_BUNDLE_W-1:0] w_main_d;
    logic [c_BUNDLE_W-1:0] w_main_q;
    logic [c_BUNDLE_W-1:0] w_skid_q;
    logic [INSTR_W-1:0]    w_out_instr;

    assign w_in_bundle = {bus.in_instr, bus.in_pc_inc, bus.in_rs_data,
                          bus.in_rt_data, bus.in_imm};

    // Handshakes; in_ready is the registered ~skid_v
    assign w_accept = bus.in_valid & ~w_skid_v;
    assign w_pop    = w_main_v & bus.out_ready;

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: occupancy after this cycle's pop/accept; flush empties everything
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_pop && !w_accept)      w_state_nxt = ST_EMPTY;
                    else if (!w_pop && w_accept) w_state_nxt = ST_FULL;
                end
                ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Slot controls: load/clear enables and main-slot source select
    always_comb begin
        w_main_load      = 1'b0;
        w_main_clr       = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clr       = 1'b0;
        if (bus.flush) begin
            // A pop in this cycle still completes at execute; only held entries die
            w_main_clr = 1'b1;
            w_skid_clr = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: w_main_load = w_accept;
                ST_ONE: begin
                    if (w_pop && w_accept) w_main_load = 1'b1;
                    else if (w_pop)        w_main_clr  = 1'b1;
                    else if (w_accept)     w_skid_load = 1'b1;
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clr       = 1'b1;
                    end
                end
                default: begin
                    w_main_clr = 1'b1;
                    w_skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_bundle;

    dx_pipe_slot #(.WIDTH(c_BUNDLE_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clr   (w_main_clr),
        .i_d     (w_main_d),
        .o_q     (w_main_q),
        .o_valid (w_main_v)
    );

    dx_pipe_slot #(.WIDTH(c_BUNDLE_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clr   (w_skid_clr),
        .i_d     (w_in_bundle),
        .o_q     (w_skid_q),
        .o_valid (w_skid_v)
    );

    assign w_out_instr     = w_main_q[c_BUNDLE_W-1 -: INSTR_W];
    assign bus.out_instr   = w_out_instr;
    assign bus.out_pc_inc  = w_main_q[4*DATA_W-1 -: DATA_W];
    assign bus.out_rs_data = w_main_q[3*DATA_W-1 -: DATA_W];
    assign bus.out_rt_data = w_main_q[2*DATA_W-1 -: DATA_W];
    assign bus.out_imm     = w_main_q[DATA_W-1:0];
    // func bits pass through even for I-format; the ALU decoder ignores them there
    assign bus.out_op_ext  = {w_out_instr[c_OPC_HI:c_OPC_LO], w_out_instr[FUNC_HI:FUNC_LO]};
    assign bus.out_valid   = w_main_v;
    assign bus.in_ready    = ~w_skid_v;

endmodule
`default_nettype wire

// File: tb/tb_decode_ex_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decode_ex_pipe                                            |
// | Description : Directed bench for decode_ex_pipe with a FIFO reference      |
// |               queue: stream, stall, flush, reset and random traffic.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_decode_ex_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_ex_pipe_if #(.DATA_W(16), .INSTR_W(16)) dx ();

    decode_ex_pipe #(.DATA_W(16), .INSTR_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dx)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int pops_before;
    logic [79:0] model[$];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] in_bundle();
        return {dx.in_instr, dx.in_pc_inc, dx.in_rs_data, dx.in_rt_data, dx.in_imm};
    endfunction

    function automatic logic [79:0] out_bundle();
        return {dx.out_instr, dx.out_pc_inc, dx.out_rs_data, dx.out_rt_data, dx.out_imm};
    endfunction

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                         input logic [15:0] rs, input logic [15:0] rt, input logic [15:0] imm);
        dx.in_valid   = v;
        dx.in_instr   = instr;
        dx.in_pc_inc  = pc;
        dx.in_rs_data = rs;
        dx.in_rt_data = rt;
        dx.in_imm     = imm;
    endtask

    // One clock: score the handshakes visible now, advance, then check occupancy
    task automatic cycle();
        logic        pop;
        logic        acc;
        logic [79:0] exp;
        pop = dx.out_valid && dx.out_ready;
        acc = dx.in_valid && dx.in_ready && !dx.flush;
        if (pop) begin
            if (model.size() == 0) begin
                chk("pop_underflow", 80'(dx.out_valid), 80'(0));
            end else begin
                exp = model.pop_front();
                chk("pop_data", out_bundle(), exp);
                chk("pop_op_ext", 80'(dx.out_op_ext), 80'({exp[79:75], exp[65:64]}));
                n_pops++;
            end
        end
        if (dx.flush) model.delete();
        else if (acc) model.push_back(in_bundle());
        @(posedge clk);
        #1;
        chk("out_valid", 80'(dx.out_valid), 80'(model.size() != 0));
        chk("in_ready", 80'(dx.in_ready), 80'(model.size() < 2));
    endtask

    initial begin
        rst_n        = 1'b0;
        dx.flush     = 1'b0;
        dx.out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", 80'(dx.out_valid), 80'(0));
        chk("rst_in_ready", 80'(dx.in_ready), 80'(1));
        chk("rst_out_bundle", out_bundle(), 80'(0));
        chk("rst_op_ext", 80'(dx.out_op_ext), 80'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD 0xD905: op_ext = {11011, 01} one cycle after accept
        dx.out_ready = 1'b1;
        drive(1'b1, 16'hD905, 16'h0002, 16'h1111, 16'h2222, 16'h0005);
        cycle();
        chk("add_op_ext", 80'(dx.out_op_ext), 80'(7'b1101101));
        chk("add_instr", 80'(dx.out_instr), 80'(16'hD905));
        chk("add_pc_inc", 80'(dx.out_pc_inc), 80'(16'h0002));
        chk("add_rs", 80'(dx.out_rs_data), 80'(16'h1111));
        chk("add_rt", 80'(dx.out_rt_data), 80'(16'h2222));
        chk("add_imm", 80'(dx.out_imm), 80'(16'h0005));

        // Eight back-to-back bundles, one per cycle
        pops_before = n_pops;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h0801 * 16'(i + 1), 16'(2 * i + 4), 16'(16'hA000 + i),
                  16'(16'hB000 + i), 16'(16'hC000 + i));
            cycle();
        end
        dx.in_valid = 1'b0;
        cycle();
        chk("stream_pop_cnt", 80'(n_pops - pops_before), 80'(9));

        // Stall: A, B fill the buffer; C waits; release drains A, B, C in order
        dx.out_ready = 1'b0;
        drive(1'b1, 16'h1A01, 16'h0100, 16'h0A0A, 16'h0A0B, 16'h0A0C);
        cycle();
        drive(1'b1, 16'h2B02, 16'h0102, 16'h0B0A, 16'h0B0B, 16'h0B0C);
        cycle();
        chk("stall_in_ready", 80'(dx.in_ready), 80'(0));
        chk("stall_head_a", 80'(dx.out_instr), 80'(16'h1A01));
        drive(1'b1, 16'h3C03, 16'h0104, 16'h0C0A, 16'h0C0B, 16'h0C0C);
        repeat (3) cycle();
        chk("stall_hold_a", 80'(dx.out_instr), 80'(16'h1A01));
        chk("stall_hold_rs", 80'(dx.out_rs_data), 80'(16'h0A0A));
        dx.out_ready = 1'b1;
        cycle();
        chk("release_head_b", 80'(dx.out_instr), 80'(16'h2B02));
        cycle();
        chk("release_head_c", 80'(dx.out_instr), 80'(16'h3C03));
        dx.in_valid = 1'b0;
        cycle();

        // Flush with a full buffer and a bundle presented: everything lost
        dx.out_ready = 1'b0;
        drive(1'b1, 16'h4D04, 16'h0200, 16'h1, 16'h2, 16'h3);
        cycle();
        drive(1'b1, 16'h5E05, 16'h0202, 16'h4, 16'h5, 16'h6);
        cycle();
        drive(1'b1, 16'h6F06, 16'h0204, 16'h7, 16'h8, 16'h9);
        dx.flush = 1'b1;
        cycle();
        chk("flush_out_valid", 80'(dx.out_valid), 80'(0));
        chk("flush_in_ready", 80'(dx.in_ready), 80'(1));
        dx.flush     = 1'b0;
        dx.in_valid  = 1'b0;
        dx.out_ready = 1'b1;
        repeat (2) cycle();
        chk("flush_nothing_out", 80'(dx.out_valid), 80'(0));

        // Flush while popping: popped bundle counts once, new input discarded
        drive(1'b1, 16'h7007, 16'h0300, 16'hAA, 16'hBB, 16'hCC);
        cycle();
        pops_before = n_pops;
        drive(1'b1, 16'h8008, 16'h0302, 16'hDD, 16'hEE, 16'hFF);
        dx.flush = 1'b1;
        cycle();
        dx.flush    = 1'b0;
        dx.in_valid = 1'b0;
        repeat (3) cycle();
        chk("flush_pop_cnt", 80'(n_pops - pops_before), 80'(1));

        // Asynchronous reset mid-stream
        dx.out_ready = 1'b0;
        drive(1'b1, 16'h9009, 16'h0400, 16'h11, 16'h22, 16'h33);
        cycle();
        drive(1'b1, 16'hA00A, 16'h0402, 16'h44, 16'h55, 16'h66);
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 80'(dx.out_valid), 80'(0));
        chk("mid_rst_in_ready", 80'(dx.in_ready), 80'(1));
        chk("mid_rst_bundle", out_bundle(), 80'(0));
        model.delete();
        dx.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Random valid/ready traffic against the reference queue
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom()), 16'($urandom()),
                  16'($urandom()), 16'($urandom()), 16'($urandom()));
            dx.out_ready = ($urandom_range(0, 3) != 0);
            dx.flush     = ($urandom_range(0, 63) == 0);
            cycle();
        end
        dx.flush     = 1'b0;
        dx.in_valid  = 1'b0;
        dx.out_ready = 1'b1;
        repeat (3) cycle();
        chk("drain_empty", 80'(dx.out_valid), 80'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
